// File: rtl/fabric_config_crc.sv
// -----------------------------------------------------------------------------
// fabric_config_crc
//
// Bitstream loader for a column/row configuration fabric. A 32-bit word stream
// carries a sync word, then headers that either write one frame (NumRows data
// words followed by a frame-strobe pulse), check the running CRC-32, or desync.
//
// Handshake: a word is transferred on a rising clk_i edge where both
// bitstream_valid_i and bitstream_ready_o are high. Ready depends only on the
// current state (low only while strobing) and never on valid.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   bitstream_data_i      incoming word
//   bitstream_valid_i     word valid
//   bitstream_ready_o     word accepted when valid is also high
//   busy_o                loader is inside a bitstream (not idle, not error)
//   configured_o          last bitstream desynced without error
//   error_o               CRC or format error latched
//   frame_count_o         frames strobed since the last sync (saturating)
//   FrameData_o           row data registers, row r at [r*32 +: 32]
//   FrameStrobe_o         frame strobes, column c at [c*MaxFramesPerCol +: ...]
//   dbg_state_o           current FSM state (debug)
// -----------------------------------------------------------------------------
module fabric_config_crc #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumColumns      = 12,
    parameter int NumRows         = 18,
    parameter int StrobeCycles    = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [31:0]                           bitstream_data_i,
    input  logic                                  bitstream_valid_i,
    output logic                                  bitstream_ready_o,
    output logic                                  busy_o,
    output logic                                  configured_o,
    output logic                                  error_o,
    output logic [15:0]                           frame_count_o,
    output logic [FrameBitsPerRow*NumRows-1:0]    FrameData_o,
    output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe_o,
    output logic [2:0]                            dbg_state_o
);

    generate
        if (FrameBitsPerRow != 32) begin : g_bad_row_bits
            $error("fabric_config_crc: FrameBitsPerRow must be 32");
        end
        if (MaxFramesPerCol < 1 || MaxFramesPerCol > 22) begin : g_bad_frames
            $error("fabric_config_crc: MaxFramesPerCol must be 1..22");
        end
        if (NumColumns < 1 || NumColumns > 256) begin : g_bad_cols
            $error("fabric_config_crc: NumColumns must be 1..256");
        end
        if (NumRows < 1) begin : g_bad_rows
            $error("fabric_config_crc: NumRows must be >= 1");
        end
        if (StrobeCycles < 1) begin : g_bad_strobe
            $error("fabric_config_crc: StrobeCycles must be >= 1");
        end
    endgenerate

    localparam int RowW  = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int StbW  = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam int DataW = FrameBitsPerRow * NumRows;

    localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;
    localparam logic [31:0] CrcPoly  = 32'h04C1_1DB7;
    localparam logic [31:0] CrcInit  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_STROBE = 3'd3,
        S_CRC    = 3'd4,
        S_ERROR  = 3'd5
    } state_e;

    state_e                      state_q, state_d;
    logic [RowW-1:0]             row_sel_q, row_sel_d;
    logic [StbW-1:0]             stb_cnt_q, stb_cnt_d;
    logic [7:0]                  col_q, col_d;
    logic [MaxFramesPerCol-1:0]  mask_q, mask_d;
    logic [31:0]                 crc_q, crc_d;
    logic                        configured_q, configured_d;
    logic                        error_q, error_d;
    logic [15:0]                 frame_count_q, frame_count_d;
    logic [DataW-1:0]            frame_data_q, frame_data_d;

    // CRC-32, MSB-first, one full word per cycle.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                               input logic [31:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ data[i]) begin
                c = (c << 1) ^ CrcPoly;
            end else begin
                c = c << 1;
            end
        end
        return c;
    endfunction

    logic                       accept;
    logic [7:0]                 hdr_col;
    logic [1:0]                 hdr_op;
    logic [MaxFramesPerCol-1:0] hdr_mask;
    logic                       hdr_col_bad;
    logic [31:0]                crc_upd;

    always_comb begin
        accept      = bitstream_valid_i && (state_q != S_STROBE);
        hdr_col     = bitstream_data_i[31:24];
        hdr_op      = bitstream_data_i[23:22];
        hdr_mask    = bitstream_data_i[MaxFramesPerCol-1:0];
        hdr_col_bad = ({1'b0, hdr_col} >= 9'(NumColumns));
        crc_upd     = crc32_next(crc_q, bitstream_data_i);
    end

    // State register plus datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            row_sel_q     <= '0;
            stb_cnt_q     <= '0;
            col_q         <= '0;
            mask_q        <= '0;
            crc_q         <= CrcInit;
            configured_q  <= 1'b0;
            error_q       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            row_sel_q     <= row_sel_d;
            stb_cnt_q     <= stb_cnt_d;
            col_q         <= col_d;
            mask_q        <= mask_d;
            crc_q         <= crc_d;
            configured_q  <= configured_d;
            error_q       <= error_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Row data registers carry no reset: their content is only meaningful
    // once a frame has been written.
    always_ff @(posedge clk_i) begin
        frame_data_q <= frame_data_d;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d       = state_q;
        row_sel_d     = row_sel_q;
        stb_cnt_d     = stb_cnt_q;
        col_d         = col_q;
        mask_d        = mask_q;
        crc_d         = crc_q;
        configured_d  = configured_q;
        error_d       = error_q;
        frame_count_d = frame_count_q;
        frame_data_d  = frame_data_q;

        unique case (state_q)
            S_IDLE, S_ERROR: begin
                // Everything except the sync word is swallowed here.
                if (accept && bitstream_data_i == SyncWord) begin
                    state_d       = S_HEADER;
                    configured_d  = 1'b0;
                    error_d       = 1'b0;
                    frame_count_d = '0;
                    crc_d         = CrcInit;
                end
            end
            S_HEADER: begin
                if (accept) begin
                    if (hdr_op == 2'b11 || hdr_col_bad) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else if (hdr_op == 2'b00) begin
                        state_d   = S_DATA;
                        col_d     = hdr_col;
                        mask_d    = hdr_mask;
                        row_sel_d = RowW'(NumRows - 1);
                        crc_d     = crc_upd;
                    end else if (hdr_op == 2'b01) begin
                        state_d      = S_IDLE;
                        configured_d = 1'b1;
                        crc_d        = crc_upd;
                    end else begin
                        // Check header is not part of the protected stream.
                        state_d = S_CRC;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    frame_data_d[int'(row_sel_q)*FrameBitsPerRow +: FrameBitsPerRow] =
                        bitstream_data_i;
                    crc_d = crc_upd;
                    if (row_sel_q == '0) begin
                        state_d   = S_STROBE;
                        stb_cnt_d = '0;
                    end else begin
                        row_sel_d = row_sel_q - 1'b1;
                    end
                end
            end
            S_STROBE: begin
                if (stb_cnt_q == StbW'(StrobeCycles - 1)) begin
                    state_d = S_HEADER;
                    if (frame_count_q != 16'hFFFF) begin
                        frame_count_d = frame_count_q + 16'd1;
                    end
                end else begin
                    stb_cnt_d = stb_cnt_q + 1'b1;
                end
            end
            S_CRC: begin
                if (accept) begin
                    if (bitstream_data_i == crc_q) begin
                        state_d = S_HEADER;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        bitstream_ready_o = (state_q != S_STROBE);
        busy_o            = (state_q != S_IDLE) && (state_q != S_ERROR);
        configured_o      = configured_q;
        error_o           = error_q;
        frame_count_o     = frame_count_q;
        FrameData_o       = frame_data_q;
        dbg_state_o       = state_q;
        FrameStrobe_o     = '0;
        if (state_q == S_STROBE) begin
            FrameStrobe_o[int'(col_q)*MaxFramesPerCol +: MaxFramesPerCol] = mask_q;
        end
    end

endmodule

// File: tb/tb_fabric_config_crc.sv
module tb_fabric_config_crc;

  localparam int NCOL = 12;
  localparam int NROW = 18;
  localparam int NFR  = 20;
  localparam int SW   = NFR * NCOL;
  localparam int DW   = 32 * NROW;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  localparam int P_IDLE  = 0;
  localparam int P_HDR   = 1;
  localparam int P_DATA  = 2;
  localparam int P_PULSE = 3;
  localparam int P_CHK   = 4;
  localparam int P_ERR   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT A (StrobeCycles = 1) ----------------
  logic [31:0] a_data;
  logic        a_valid, a_ready, a_busy, a_cfg, a_err;
  logic [15:0] a_fc;
  logic [DW-1:0] a_fd;
  logic [SW-1:0] a_stb;
  logic [2:0]  a_dbg;

  fabric_config_crc #(.StrobeCycles(1)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .bitstream_data_i(a_data), .bitstream_valid_i(a_valid),
    .bitstream_ready_o(a_ready), .busy_o(a_busy),
    .configured_o(a_cfg), .error_o(a_err), .frame_count_o(a_fc),
    .FrameData_o(a_fd), .FrameStrobe_o(a_stb), .dbg_state_o(a_dbg)
  );

  // ---------------- DUT B (StrobeCycles = 3) ----------------
  logic [31:0] b_data;
  logic        b_valid, b_ready, b_busy, b_cfg, b_err;
  logic [15:0] b_fc;
  logic [DW-1:0] b_fd;
  logic [SW-1:0] b_stb;
  logic [2:0]  b_dbg;

  fabric_config_crc #(.StrobeCycles(3)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .bitstream_data_i(b_data), .bitstream_valid_i(b_valid),
    .bitstream_ready_o(b_ready), .busy_o(b_busy),
    .configured_o(b_cfg), .error_o(b_err), .frame_count_o(b_fc),
    .FrameData_o(b_fd), .FrameStrobe_o(b_stb), .dbg_state_o(b_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // CRC as polynomial long division: next = ((crc ^ word) * x^32) mod P.
  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [31:0] d);
    logic [63:0] r;
    r = {c ^ d, 32'h0};
    for (int i = 63; i >= 32; i--) begin
      if (r[i]) r[i -: 33] = r[i -: 33] ^ 33'h1_04C1_1DB7;
    end
    return r[31:0];
  endfunction

  function automatic logic [SW-1:0] strobe_of(input logic [7:0] col, input logic [19:0] mask);
    logic [SW-1:0] v;
    v = '0;
    v[int'(col)*NFR +: NFR] = mask;
    return v;
  endfunction

  function automatic logic [31:0] hdr(input int col, input int op, input logic [19:0] mask);
    logic [31:0] h;
    h = '0;
    h[31:24] = col[7:0];
    h[23:22] = op[1:0];
    h[19:0]  = mask;
    return h;
  endfunction

  int          m_phase = P_IDLE;
  logic [31:0] m_crc = 32'hFFFF_FFFF;
  logic        m_cfg = 1'b0;
  logic        m_err = 1'b0;
  int          m_fc = 0;
  logic [7:0]  m_col = '0;
  logic [19:0] m_mask = '0;
  int          m_rows_left = 0;
  int          m_pulse_left = 0;
  logic [31:0] m_rows [NROW];
  bit          m_known [NROW];

  task automatic model_reset();
    m_phase = P_IDLE;
    m_crc   = 32'hFFFF_FFFF;
    m_cfg   = 1'b0;
    m_err   = 1'b0;
    m_fc    = 0;
  endtask

  task automatic model_accept(input logic [31:0] w);
    int col;
    int op;
    col = int'(w[31:24]);
    op  = int'(w[23:22]);
    case (m_phase)
      P_IDLE, P_ERR: begin
        if (w == SYNC) begin
          m_phase = P_HDR; m_cfg = 1'b0; m_err = 1'b0; m_fc = 0; m_crc = 32'hFFFF_FFFF;
        end
      end
      P_HDR: begin
        if (op == 3 || col >= NCOL) begin
          m_phase = P_ERR; m_err = 1'b1;
        end else if (op == 0) begin
          m_crc = crc_ref(m_crc, w);
          m_col = w[31:24]; m_mask = w[19:0];
          m_rows_left = NROW; m_phase = P_DATA;
        end else if (op == 1) begin
          m_crc = crc_ref(m_crc, w);
          m_cfg = 1'b1; m_phase = P_IDLE;
        end else begin
          m_phase = P_CHK;
        end
      end
      P_DATA: begin
        m_rows[m_rows_left - 1]  = w;
        m_known[m_rows_left - 1] = 1'b1;
        m_crc = crc_ref(m_crc, w);
        m_rows_left--;
        if (m_rows_left == 0) begin
          m_phase = P_PULSE; m_pulse_left = 1;
        end
      end
      P_CHK: begin
        if (w == m_crc) m_phase = P_HDR;
        else begin m_phase = P_ERR; m_err = 1'b1; end
      end
      default: ;
    endcase
  endtask

  int            stb_seen_cnt = 0;
  logic [SW-1:0] stb_seen_val = '0;

  // Per-cycle compare of DUT A against the model.
  always @(posedge clk) begin
    if (rst) model_reset();
    else if (m_phase == P_PULSE) begin
      m_pulse_left--;
      if (m_pulse_left == 0) begin
        if (m_fc < 65535) m_fc++;
        m_phase = P_HDR;
      end
    end else if (a_valid) model_accept(a_data);
    #1;
    check("ready", a_ready, m_phase != P_PULSE);
    check("busy", a_busy, !(m_phase == P_IDLE || m_phase == P_ERR));
    check("configured", a_cfg, m_cfg);
    check("error", a_err, m_err);
    check("frame_count", a_fc, m_fc[15:0]);
    check("strobe", a_stb, (m_phase == P_PULSE) ? strobe_of(m_col, m_mask) : '0);
    for (int r = 0; r < NROW; r++) begin
      if (m_known[r]) check($sformatf("row%0d", r), a_fd[r*32 +: 32], m_rows[r]);
    end
    if (a_stb != '0) begin
      stb_seen_cnt++;
      stb_seen_val = a_stb;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] w, input int gap);
    int   n;
    logic acc;
    acc = 1'b0;
    if (gap > 0) begin
      n = $urandom_range(0, gap);
      repeat (n) begin @(negedge clk); a_valid = 1'b0; end
    end
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = w;
    for (int k = 0; k < 64; k++) begin
      acc = a_ready;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL handshake_timeout: word %h not accepted within 64 cycles", w);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic send_frame(input int col, input logic [19:0] mask, input int gap, input int sync_at);
    send_word(hdr(col, 0, mask), gap);
    for (int i = 0; i < NROW; i++) begin
      send_word((i == sync_at) ? SYNC : 32'($urandom), gap);
    end
  endtask

  // ---------------- main sequence ----------------
  logic [31:0]   v;
  logic [SW-1:0] one_hot;
  logic [31:0]   bw [21];

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    for (int r = 0; r < NROW; r++) m_known[r] = 1'b0;

    // Literal pins on the reference CRC.
    check("crc_pin_ff_ff", crc_ref(32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0000);
    check("crc_pin_ff_fe", crc_ref(32'hFFFF_FFFF, 32'hFFFF_FFFE), 32'h04C1_1DB7);
    check("crc_pin_0_1",   crc_ref(32'h0, 32'h1), 32'h04C1_1DB7);
    check("crc_pin_0_2",   crc_ref(32'h0, 32'h2), 32'h0982_3B6E);

    repeat (3) @(negedge clk);
    check("rst_ready", a_ready, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_cfg", a_cfg, 1'b0);
    check("rst_err", a_err, 1'b0);
    check("rst_fc", a_fc, 16'd0);
    check("rst_strobe", a_stb, '0);
    check("rst_b_ready", b_ready, 1'b1);
    rst = 1'b0;

    // V1: one frame, valid held high, then desync.
    stb_seen_cnt = 0;
    send_word(SYNC, 0);
    send_frame(3, 20'h00001, 0, -1);
    send_word(hdr(0, 1, 20'h0), 0);
    idle();
    one_hot = '0;
    one_hot[60] = 1'b1;
    check("v1_fc", a_fc, 16'd1);
    check("v1_cfg", a_cfg, 1'b1);
    check("v1_strobe_cycles", stb_seen_cnt, 1);
    check("v1_strobe_val", stb_seen_val, one_hot);

    // V3: CRC check pass, then CRC check fail.
    send_word(SYNC, 1);
    send_frame(5, 20'($urandom), 2, -1);
    send_word(hdr(0, 2, 20'h0), 1);
    idle();
    v = m_crc;
    send_word(v, 0);
    send_word(hdr(0, 1, 20'h0), 1);
    idle();
    check("v3_pass_err", a_err, 1'b0);
    check("v3_pass_cfg", a_cfg, 1'b1);

    send_word(SYNC, 1);
    send_frame(7, 20'($urandom), 1, -1);
    send_word(hdr(0, 2, 20'h0), 1);
    send_word(32'h0, 0);
    idle();
    check("v3_fail_err", a_err, 1'b1);
    check("v3_fail_cfg", a_cfg, 1'b0);
    check("v3_fail_busy", a_busy, 1'b0);

    // V4: out-of-range column, discard in error, resync, bad opcode.
    send_word(SYNC, 0);
    idle();
    check("v4_sync_clears_err", a_err, 1'b0);
    send_word(hdr(12, 0, 20'h1), 0);
    idle();
    check("v4_col_err", a_err, 1'b1);
    check("v4_col_busy", a_busy, 1'b0);
    send_word(32'h1234_5678, 1);
    send_word(hdr(0, 0, 20'h1), 1);
    idle();
    check("v4_discard_err", a_err, 1'b1);
    check("v4_discard_fc", a_fc, 16'd0);
    send_word(SYNC, 1);
    idle();
    check("v4_resync_err", a_err, 1'b0);
    check("v4_resync_busy", a_busy, 1'b1);
    send_word(hdr(0, 3, 20'h0), 0);
    idle();
    check("v4_op11_err", a_err, 1'b1);

    // V5: reset after 5 data words, then a full bitstream.
    send_word(SYNC, 0);
    send_word(hdr(2, 0, 20'hABCDE), 0);
    for (int i = 0; i < 5; i++) send_word(32'($urandom), 1);
    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("v5_after_rst_busy", a_busy, 1'b0);
    check("v5_after_rst_strobe", a_stb, '0);
    send_word(SYNC, 1);
    send_frame(2, 20'hABCDE, 1, -1);
    send_word(hdr(0, 1, 20'h0), 1);
    idle();
    check("v5_cfg", a_cfg, 1'b1);
    check("v5_fc", a_fc, 16'd1);

    // V6: four frames with random gaps, one carrying the sync word as data.
    send_word(SYNC, 2);
    for (int f = 0; f < 4; f++) begin
      send_frame($urandom_range(0, NCOL - 1), 20'($urandom), 3, (f == 1) ? 7 : -1);
    end
    send_word(hdr(0, 1, 20'h0), 2);
    idle();
    check("v6_fc", a_fc, 16'd4);
    check("v6_cfg", a_cfg, 1'b1);

    // V2 on DUT B: strobe width 3 with valid held high.
    bw[0]  = SYNC;
    bw[1]  = hdr(1, 0, 20'h00003);
    for (int i = 2; i < 20; i++) bw[i] = $urandom;
    bw[20] = hdr(0, 1, 20'h0);
    begin
      int idx;
      int cyc;
      int rdy_low;
      int stb_n;
      logic r;
      logic [SW-1:0] stb_v;
      idx = 0; cyc = 0; rdy_low = 0; stb_n = 0; stb_v = '0;
      while (idx < 21 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        b_valid = 1'b1;
        b_data  = bw[idx];
        if (!b_ready) rdy_low++;
        if (b_stb != '0) begin stb_n++; stb_v = b_stb; end
        r = b_ready;
        @(posedge clk);
        if (r) idx++;
      end
      @(negedge clk);
      b_valid = 1'b0;
      check("v2_all_words", idx, 21);
      check("v2_ready_low", rdy_low, 3);
      check("v2_strobe_width", stb_n, 3);
      check("v2_strobe_val", stb_v, strobe_of(8'd1, 20'h00003));
      check("v2_fc", b_fc, 16'd1);
      check("v2_cfg", b_cfg, 1'b1);
      for (int rr = 0; rr < NROW; rr++) begin
        check($sformatf("v2_row%0d", rr), b_fd[rr*32 +: 32], bw[2 + (NROW - 1 - rr)]);
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fabric_config_crc.md
FABRIC_CONFIG_CRC -- requirements
Module: fabric_config_crc

Interface
REQ-001 SHALL have parameter FrameBitsPerRow, default 32, meaning bits per row word; only 32 is legal, any other value fails elaboration.
REQ-002 SHALL have parameter MaxFramesPerCol, default 20, meaning frame strobes per column; legal range 1..22.
REQ-003 SHALL have parameter NumColumns, default 12, meaning fabric columns; legal range 1..256.
REQ-004 SHALL have parameter NumRows, default 18, meaning fabric rows; legal range >= 1.
REQ-005 SHALL have parameter StrobeCycles, default 1, meaning frame strobe pulse width in cycles; legal range >= 1.
REQ-006 SHALL have port clk_i, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit, meaning reset: asynchronous, active-high.
REQ-008 SHALL have port bitstream_data_i, input, 32 bits, meaning bitstream word.
REQ-009 SHALL have port bitstream_valid_i, input, 1 bit, meaning the word is valid.
REQ-010 SHALL have port bitstream_ready_o, output, 1 bit, meaning the word is accepted this cycle when valid is also high.
REQ-011 SHALL have port busy_o, output, 1 bit, meaning the state is not S_IDLE and not S_ERROR.
REQ-012 SHALL have port configured_o, output, 1 bit, meaning the last bitstream desynced without error.
REQ-013 SHALL have port error_o, output, 1 bit, meaning a CRC or format error is latched.
REQ-014 SHALL have port frame_count_o, output, 16 bits, meaning frames strobed since the last sync; saturates at 0xFFFF.
REQ-015 SHALL have port FrameData_o, output, FrameBitsPerRow*NumRows bits, meaning row data registers.
REQ-016 SHALL have port FrameStrobe_o, output, MaxFramesPerCol*NumColumns bits, meaning global frame strobes.

Function
REQ-017 SHALL treat a word as accepted only when valid and ready are both high; ready is high in every state except S_STROBE.
REQ-018 SHALL use states S_IDLE, S_HEADER, S_DATA, S_STROBE, S_CRC and S_ERROR.
REQ-019 SHALL go from S_IDLE or S_ERROR to S_HEADER on accepting the sync word 0xFAB0FAB1; this also clears configured_o, error_o and frame_count_o and sets the CRC register to 0xFFFFFFFF.
REQ-020 SHALL decode the header fields as: [31:24] column, [23:22] opcode, [MaxFramesPerCol-1:0] frame mask.
REQ-021 SHALL, in S_HEADER with opcode 00 (write): go to S_DATA and latch column and mask; row_select is set to NumRows-1.
REQ-022 SHALL, in S_HEADER with opcode 01 (desync): go to S_IDLE and set configured_o to 1.
REQ-023 SHALL, in S_HEADER with opcode 10 (check): go to S_CRC.
REQ-024 SHALL, in S_HEADER, go to S_ERROR and set error_o on opcode 11 or on column >= NumColumns.
REQ-025 SHALL, in S_DATA, write each accepted word into the row register at row_select and then decrement row_select; the first word goes to row NumRows-1 and the last to row 0.
REQ-026 SHALL, on accepting the row-0 word, enter S_STROBE on the next cycle.
REQ-027 SHALL, in S_STROBE, drive FrameStrobe_o[col*MaxFramesPerCol +: MaxFramesPerCol] = mask and all other bits to 0, for exactly StrobeCycles cycles.
REQ-028 SHALL, at the end of S_STROBE, increment frame_count_o (saturating) and return to S_HEADER.
REQ-029 SHALL hold FrameStrobe_o at all-zero outside S_STROBE.
REQ-030 SHALL update the CRC on every accepted word in S_HEADER (opcodes 00 and 01) and S_DATA: CRC-32, polynomial 0x04C11DB7, MSB-first, 32 bits per cycle, no reflection, no final XOR.
REQ-031 SHALL exclude from the CRC the sync word, the check header and the check value.
REQ-032 SHALL, in S_CRC, compare the accepted word with the CRC register: on a match go to S_HEADER with the CRC unchanged; on a mismatch go to S_ERROR and set error_o.
REQ-033 SHALL, in S_ERROR, accept and discard every word except the sync word; configured_o stays 0 and frames already strobed are not reverted.
REQ-034 SHALL accept a sync word that arrives in S_HEADER, S_DATA or S_CRC as ordinary data, not as a resync.
REQ-035 SHALL apply one-cycle latency from an accepted word to a register or state update; there are no idle-cycle requirements.

Reset
REQ-036 SHALL, while rst_i is high, force state S_IDLE, ready 1, busy/configured/error 0, frame_count 0, FrameStrobe_o 0, CRC 0xFFFFFFFF and row_select 0; FrameData_o row registers have no reset.
REQ-037 SHALL, on reset mid-frame, abort with no strobe and resume from S_IDLE.

Verification
V1: sync, header col 3 / opcode 00 / mask 0x00001, 18 data words (valid held high), header opcode 01 -> col-3 bit 0 strobes 1 cycle; frame_count_o 1; configured_o 1.
V2: StrobeCycles=3; same frame with valid held high -> ready low for exactly 3 cycles; strobe width 3; no word lost.
V3: one frame, then opcode-10 header with the model CRC value -> no error; then desync -> configured_o 1. Repeat with value 0x00000000 -> error_o 1, configured_o 0, busy_o 0.
V4: header with column 12 (NumColumns=12) -> S_ERROR, error_o 1, no strobe; following sync clears error_o.
V5: rst_i asserted after 5 of 18 data words -> FrameStrobe_o stays 0; after release, a full bitstream configures normally.
V6: random valid gaps over 4 frames -> FrameData_o rows and strobe masks match the model; frame_count_o 4.
